// File: rtl/dphy_lane_byte_align.sv
// -----------------------------------------------------------------------------
// dphy_lane_byte_align
//
// Multi-lane D-PHY HS byte aligner. Each lane hunts on its own for the HS sync
// byte (preceded by HS-zero bits) in a two-byte sliding window. It then locks to
// the bit offset of the match and emits realigned payload bytes until
// end-of-packet. Lanes are fully independent, and no inter-lane deskew is done.
//
// Optional feature macro: DPHY_SYNC_SOFT_ERR_EN
//   defined   - if no lane offset has an exact sync match, a sync byte with a
//               single bit error (and a valid zero prefix) is accepted. Locking
//               this way pulses sync_soft_err_o for that lane.
//   undefined - exact match only, and sync_soft_err_o is always 0.
//
// Ports:
//   clk_i             in   1        byte clock
//   rst_n_i           in   1        synchronous active-low reset
//   enable_i          in   1        global enable; low forces all lanes to IDLE
//   packet_done_i     in   LANES    per-lane end of packet (LOCKED -> HUNT)
//   unaligned_data_i  in   LANES*8  lane n on [8n+7:8n], earliest bit in LSB
//   aligned_data_o    out  LANES*8  aligned payload bytes, same packing
//   valid_o           out  LANES    per-lane byte valid
//   locked_o          out  LANES    lane is in LOCKED
//   sync_timeout_o    out  LANES    one-cycle pulse on HUNT timeout
//   sync_soft_err_o   out  LANES    one-cycle pulse on lock via 1-bit-error sync
// -----------------------------------------------------------------------------
module dphy_lane_byte_align #(
  parameter int unsigned LANES        = 4,
  parameter logic [7:0]  SYNC_PATTERN = 8'hB8,
  parameter int unsigned SYNC_TIMEOUT = 1024,
  parameter int unsigned TO_CNT_W     = 11
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               enable_i,
  input  logic [LANES-1:0]   packet_done_i,
  input  logic [LANES*8-1:0] unaligned_data_i,
  output logic [LANES*8-1:0] aligned_data_o,
  output logic [LANES-1:0]   valid_o,
  output logic [LANES-1:0]   locked_o,
  output logic [LANES-1:0]   sync_timeout_o,
  output logic [LANES-1:0]   sync_soft_err_o
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StHunt   = 2'd1,
    StLocked = 2'd2
  } state_e;

  localparam bit                  ToEn   = (SYNC_TIMEOUT != 0);
  localparam logic [TO_CNT_W-1:0] ToLast = ToEn ? TO_CNT_W'(SYNC_TIMEOUT - 1) : '0;
  // With a timeout of 1, every HUNT cycle is a timeout cycle, including the
  // first one after entering HUNT.
  localparam bit                  ToPulseOnEntry = ToEn && (ToLast == '0);

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    state_e              r_state;
    logic [7:0]          r_d1;
    logic [7:0]          r_d2;
    logic [2:0]          r_off;
    logic [TO_CNT_W-1:0] r_to_cnt;
    logic [7:0]          r_data;
    logic                r_valid;
    logic                r_locked;
    logic                r_to_pulse;
    logic                r_soft;

    logic [15:0]         w_win;
    logic [7:0]          w_field;
    logic                w_zero_ok;
    logic                w_exact_hit;
    logic [2:0]          w_exact_k;
    logic                w_soft_hit;
    logic [2:0]          w_soft_k;
    logic                w_cand;
    logic [2:0]          w_cand_k;
    logic                w_cand_soft;
    logic [7:0]          w_aligned;
    logic [TO_CNT_W-1:0] w_to_cnt_nxt;

    // The newer byte sits in the upper half, so bit index increases with time.
    assign w_win = {r_d1, r_d2};

    // Scan k in ascending order so that later (higher) offsets override earlier ones.
    always_comb begin
      w_field     = '0;
      w_zero_ok   = 1'b0;
      w_exact_hit = 1'b0;
      w_exact_k   = '0;
      for (int k = 0; k < 8; k++) begin
        w_field   = w_win[k+1 +: 8];
        // The shift keeps only bits [k:0], which must all be HS-zero.
        w_zero_ok = ((w_win << (15 - k)) == 16'h0000);
        if (w_zero_ok && (w_field == SYNC_PATTERN)) begin
          w_exact_hit = 1'b1;
          w_exact_k   = 3'(k);
        end
      end
    end

`ifdef DPHY_SYNC_SOFT_ERR_EN
    logic [7:0] w_diff;
    logic [7:0] w_sfield;
    logic       w_szero;

    always_comb begin
      w_diff     = '0;
      w_sfield   = '0;
      w_szero    = 1'b0;
      w_soft_hit = 1'b0;
      w_soft_k   = '0;
      for (int k = 0; k < 8; k++) begin
        w_sfield = w_win[k+1 +: 8];
        w_szero  = ((w_win << (15 - k)) == 16'h0000);
        w_diff   = w_sfield ^ SYNC_PATTERN;
        // Exactly one bit set means Hamming distance 1.
        if (w_szero && (w_diff != 8'h00) && ((w_diff & (w_diff - 8'd1)) == 8'h00)) begin
          w_soft_hit = 1'b1;
          w_soft_k   = 3'(k);
        end
      end
    end
`else
    assign w_soft_hit = 1'b0;
    assign w_soft_k   = 3'd0;
`endif

    // An exact match at any offset takes priority over every soft match.
    assign w_cand      = w_exact_hit || w_soft_hit;
    assign w_cand_k    = w_exact_hit ? w_exact_k : w_soft_k;
    assign w_cand_soft = !w_exact_hit && w_soft_hit;

    assign w_aligned    = w_win[int'(r_off) + 1 +: 8];
    assign w_to_cnt_nxt = (r_to_cnt == ToLast) ? '0 : r_to_cnt + 1'b1;

    // Lane FSM plus registered outputs. The pulse and valid outputs default low
    // each cycle. Each branch raises them only for the cycle that follows.
    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        r_state    <= StIdle;
        r_d1       <= '0;
        r_d2       <= '0;
        r_off      <= '0;
        r_to_cnt   <= '0;
        r_data     <= '0;
        r_valid    <= 1'b0;
        r_locked   <= 1'b0;
        r_to_pulse <= 1'b0;
        r_soft     <= 1'b0;
      end else begin
        r_d1       <= unaligned_data_i[8*n +: 8];
        r_d2       <= r_d1;
        r_valid    <= 1'b0;
        r_to_pulse <= 1'b0;
        r_soft     <= 1'b0;
        if (!enable_i) begin
          r_state  <= StIdle;
          r_locked <= 1'b0;
          r_to_cnt <= '0;
        end else begin
          case (r_state)
            StIdle: begin
              r_state    <= StHunt;
              r_to_cnt   <= '0;
              r_to_pulse <= ToPulseOnEntry;
            end
            StHunt: begin
              if (w_cand) begin
                r_state  <= StLocked;
                r_off    <= w_cand_k;
                r_locked <= 1'b1;
                r_soft   <= w_cand_soft;
                r_to_cnt <= '0;
              end else if (ToEn) begin
                r_to_cnt   <= w_to_cnt_nxt;
                r_to_pulse <= (w_to_cnt_nxt == ToLast);
              end
            end
            StLocked: begin
              // Sync matches are deliberately ignored here, so payload bytes
              // that equal the sync byte never re-align the lane.
              if (packet_done_i[n]) begin
                r_state    <= StHunt;
                r_locked   <= 1'b0;
                r_to_cnt   <= '0;
                r_to_pulse <= ToPulseOnEntry;
              end else begin
                r_valid <= 1'b1;
                r_data  <= w_aligned;
              end
            end
            default: begin
              r_state  <= StIdle;
              r_locked <= 1'b0;
            end
          endcase
        end
      end
    end

    assign aligned_data_o[8*n +: 8] = r_data;
    assign valid_o[n]               = r_valid;
    assign locked_o[n]              = r_locked;
    assign sync_timeout_o[n]        = r_to_pulse;
    assign sync_soft_err_o[n]       = r_soft;
  end

endmodule

// File: tb/tb_dphy_lane_byte_align.sv
module tb_dphy_lane_byte_align;

  localparam int unsigned Lanes = 2;

  logic               clk_i = 1'b0;
  logic               rst_n_i;
  logic               enable_i;
  logic [Lanes-1:0]   packet_done_i;
  logic [Lanes*8-1:0] unaligned_data_i;
  logic [Lanes*8-1:0] aligned_data_o;
  logic [Lanes-1:0]   valid_o;
  logic [Lanes-1:0]   locked_o;
  logic [Lanes-1:0]   sync_timeout_o;
  logic [Lanes-1:0]   sync_soft_err_o;

  int n_checks = 0;
  int n_fails  = 0;

  dphy_lane_byte_align #(
    .LANES        (Lanes),
    .SYNC_PATTERN (8'hB8),
    .SYNC_TIMEOUT (16),
    .TO_CNT_W     (5)
  ) u_dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .enable_i         (enable_i),
    .packet_done_i    (packet_done_i),
    .unaligned_data_i (unaligned_data_i),
    .aligned_data_o   (aligned_data_o),
    .valid_o          (valid_o),
    .locked_o         (locked_o),
    .sync_timeout_o   (sync_timeout_o),
    .sync_soft_err_o  (sync_soft_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of input. Outputs are then sampled 1 time unit after the edge.
  task automatic tick(input logic [7:0] b0, input logic [7:0] b1, input logic [1:0] pd);
    unaligned_data_i = {b1, b0};
    packet_done_i    = pd;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_n_i          = 1'b0;
    enable_i         = 1'b0;
    packet_done_i    = '0;
    unaligned_data_i = '0;
    tick(8'h00, 8'h00, 2'b00);
    tick(8'h00, 8'h00, 2'b00);
    check_eq("rst_valid", 32'(valid_o), 32'h0);
    check_eq("rst_locked", 32'(locked_o), 32'h0);
    check_eq("rst_data", 32'(aligned_data_o), 32'h0);
    check_eq("rst_timeout", 32'(sync_timeout_o), 32'h0);
    check_eq("rst_soft", 32'(sync_soft_err_o), 32'h0);

    // Offset 7: 00,00,B8,11,22
    rst_n_i  = 1'b1;
    enable_i = 1'b1;
    tick(8'h00, 8'h00, 2'b00);
    check_eq("hunt_locked", 32'(locked_o), 32'h0);
    tick(8'h00, 8'h00, 2'b00);
    tick(8'hB8, 8'h00, 2'b00);
    tick(8'h11, 8'h00, 2'b00);
    check_eq("o7_locked", 32'(locked_o), 32'h1);
    check_eq("o7_novalid", 32'(valid_o), 32'h0);
    tick(8'h22, 8'h00, 2'b00);
    check_eq("o7_valid", 32'(valid_o), 32'h1);
    check_eq("o7_b0", 32'(aligned_data_o[7:0]), 32'h11);
    // Payload equal to sync must not re-align.
    tick(8'hB8, 8'h00, 2'b00);
    check_eq("o7_b1", 32'(aligned_data_o[7:0]), 32'h22);
    tick(8'hB8, 8'h00, 2'b00);
    check_eq("o7_b2", 32'(aligned_data_o[7:0]), 32'hB8);
    tick(8'h33, 8'h00, 2'b00);
    check_eq("o7_b3", 32'(aligned_data_o[7:0]), 32'hB8);
    tick(8'h00, 8'h00, 2'b00);
    check_eq("o7_b4", 32'(aligned_data_o[7:0]), 32'h33);
    check_eq("o7_lane1", 32'({valid_o[1], locked_o[1]}), 32'h0);
    tick(8'h00, 8'h00, 2'b01);
    check_eq("pd_valid", 32'(valid_o), 32'h0);
    check_eq("pd_locked", 32'(locked_o), 32'h0);
    check_eq("pd_hold", 32'(aligned_data_o[7:0]), 32'h33);

    // Offset 2: 00,C0,D5,02 -> 5A
    tick(8'hC0, 8'h00, 2'b00);
    tick(8'hD5, 8'h00, 2'b00);
    tick(8'h02, 8'h00, 2'b00);
    check_eq("o2_locked", 32'(locked_o), 32'h1);
    check_eq("o2_novalid", 32'(valid_o), 32'h0);
    tick(8'h00, 8'h00, 2'b00);
    check_eq("o2_valid", 32'(valid_o), 32'h1);
    check_eq("o2_b0", 32'(aligned_data_o[7:0]), 32'h5A);
    tick(8'h00, 8'h00, 2'b01);
    check_eq("o2_pd_locked", 32'(locked_o), 32'h0);

    // Timeout: period 16 on both lanes; lane0 locks mid-count and goes quiet.
    enable_i = 1'b0;
    tick(8'h00, 8'h00, 2'b00);
    check_eq("dis_locked", 32'(locked_o), 32'h0);
    enable_i = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      logic p0;
      logic p1;
      tick((i == 21) ? 8'hB8 : 8'h00, 8'h00, 2'b00);
      p0 = (i <= 21) && (i % 16 == 0);
      p1 = (i % 16 == 0);
      check_eq($sformatf("to_pulse_%0d", i), 32'(sync_timeout_o), 32'({p1, p0}));
      check_eq($sformatf("to_lock_%0d", i), 32'(locked_o), 32'(i >= 22));
    end

    // Synchronous reset while locked
    rst_n_i = 1'b0;
    tick(8'h00, 8'h00, 2'b00);
    check_eq("rl_valid", 32'(valid_o), 32'h0);
    check_eq("rl_locked", 32'(locked_o), 32'h0);
    check_eq("rl_data", 32'(aligned_data_o), 32'h0);
    rst_n_i = 1'b1;
    tick(8'h00, 8'h00, 2'b00);
    tick(8'h00, 8'h00, 2'b00);
    tick(8'h00, 8'h00, 2'b00);
    check_eq("rl_stay", 32'(locked_o), 32'h0);
    tick(8'hB8, 8'h00, 2'b00);
    tick(8'h77, 8'h00, 2'b00);
    check_eq("rl_relock", 32'(locked_o), 32'h1);
    tick(8'h00, 8'h00, 2'b00);
    check_eq("rl_b0", 32'(aligned_data_o[7:0]), 32'h77);
    check_eq("rl_valid2", 32'(valid_o), 32'h1);

    // Enable low while locked
    enable_i = 1'b0;
    tick(8'h00, 8'h00, 2'b00);
    check_eq("en_valid", 32'(valid_o), 32'h0);
    check_eq("en_locked", 32'(locked_o), 32'h0);
    check_eq("en_hold", 32'(aligned_data_o[7:0]), 32'h77);

    // 1-bit-error sync: 00,B9,44
    enable_i = 1'b1;
    tick(8'h00, 8'h00, 2'b00);
    tick(8'h00, 8'h00, 2'b00);
    tick(8'hB9, 8'h00, 2'b00);
    tick(8'h44, 8'h00, 2'b00);
`ifdef DPHY_SYNC_SOFT_ERR_EN
    check_eq("se_locked", 32'(locked_o), 32'h1);
    check_eq("se_pulse", 32'(sync_soft_err_o), 32'h1);
    tick(8'h00, 8'h00, 2'b00);
    check_eq("se_pulse_end", 32'(sync_soft_err_o), 32'h0);
    check_eq("se_valid", 32'(valid_o), 32'h1);
    check_eq("se_b0", 32'(aligned_data_o[7:0]), 32'h44);
`else
    check_eq("se_locked", 32'(locked_o), 32'h0);
    check_eq("se_pulse", 32'(sync_soft_err_o), 32'h0);
    tick(8'h00, 8'h00, 2'b00);
    check_eq("se_valid", 32'(valid_o), 32'h0);
    check_eq("se_locked2", 32'(locked_o), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
